mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//  Shares the 8-bit 2:1 byte multiplexer between two streaming requesters (A, B).
//  Sequences the mux select S with a round-robin, burst-limited ownership FSM and registers
//  the selected byte into a one-entry output slot with a valid/ready handshake.
//  Sits between two byte producers and a single byte consumer. Exports S for debug and for
//  observability by the bench.
// PARAMETERS
//  WIDTH      8   data width of both inputs and the output
//  MAX_BURST  4   max consecutive transfers per ownership; legal 1..15
//  CNT_W      4   burst counter width; must satisfy 2**CNT_W > MAX_BURST
// PORTS
//  CLK      in   1      single clock; all state updates on the rising edge
//  RST_N    in   1      asynchronous, active-low reset
//  A_VALID  in   1      requester A has a byte; held until A_READY
//  A_DATA   in   WIDTH  requester A byte; stable while A_VALID
//  A_READY  out  1      A byte accepted this cycle
//  B_VALID  in   1      requester B has a byte; held until B_READY
//  B_DATA   in   WIDTH  requester B byte
//  B_READY  out  1      B byte accepted this cycle
//  Y_VALID  out  1      output slot full
//  Y_DATA   out  WIDTH  registered output byte
//  Y_SRC    out  1      source of Y_DATA: 0=A, 1=B
//  Y_READY  in   1      consumer takes Y_DATA this cycle when Y_VALID
//  S        out  1      mux select: 0=A, 1=B; equals the current owner (0 when IDLE)
//  BUSY     out  1      1 when FSM is not IDLE or Y_VALID=1
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, last=B (A wins the first tie), burst_cnt=0,
//   Y_VALID=0, Y_DATA=0, Y_SRC=0, S=0, A_READY=B_READY=0. An in-flight byte is dropped.
//  FSM states: IDLE, OWN_A, OWN_B. S=1 only in OWN_B.
//  slot_free = !Y_VALID || Y_READY. xfer = owner's VALID && slot_free (combinational).
//  A_READY = (state==OWN_A) && slot_free; B_READY likewise. Never both 1.
//  Rearbitrate(last): both VALID -> the port != last; one VALID -> that port; none -> IDLE.
//  IDLE: next = rearbitrate(last); burst_cnt=0. No transfer happens in IDLE.
//  OWN_x: on xfer, burst_cnt++, last<=x, Y_DATA<=mux output, Y_SRC<=x, Y_VALID<=1.
//   Leave OWN_x when (xfer && burst_cnt+1==MAX_BURST) or !x_VALID: next = rearbitrate(x)
//   evaluated that cycle; burst_cnt<=0 on any state change.
//   A burst reaching MAX_BURST while only x is VALID re-grants x (new burst, cnt=0).
//  Latency: VALID rising in IDLE -> READY no earlier than the next cycle;
//   accepted byte on Y_DATA the cycle after xfer.
//  Throughput: 1 byte/cycle within a burst while Y_READY=1; one bubble per ownership change.
//  Output slot: xfer && !Y_READY-drain -> load; xfer with simultaneous drain -> load new,
//   Y_VALID stays 1; drain without xfer -> Y_VALID<=0; Y_VALID && !Y_READY -> hold all.
//  Y_DATA/Y_SRC change only on xfer. No byte is lost or duplicated.
//  Fairness: with both requesters continuously VALID, grants alternate in bursts of
//   exactly MAX_BURST bytes; worst-case wait = MAX_BURST transfers + 1 cycle.
//  MAX_BURST=1: strict per-byte alternation whenever both requesters are VALID.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/OWN_A/OWN_B), port ID constants SRC_A=0,
//   SRC_B=1, and the MAX_BURST legal range.
//  One sub-module instance: the existing 8-bit 2:1 mux (module MUX8) as the datapath,
//   with S driven from the FSM. For WIDTH != 8, use an inline ternary.
//  The FSM, burst counter and output slot live in this module.
// TESTING
//  Reset mid-burst: drop RST_N while OWN_A and Y_VALID=1 -> same cycle Y_VALID=0, S=0,
//   READYs=0; after release, A is granted first on a tie.
//  Single requester: A sends 0x11..0x16, Y_READY=1 -> Y_DATA 0x11..0x16 in order, Y_SRC=0,
//   a one-cycle re-grant bubble after byte 4 (MAX_BURST=4), no B grant.
//  Contention: A=0xA0.., B=0xB0.. both always VALID -> Y shows 4 A, 4 B, 4 A; S toggles;
//   first owner is A.
//  Backpressure: hold Y_READY=0 for 5 cycles with Y_VALID=1 -> Y_DATA stable, both READYs=0;
//   releasing Y_READY -> next byte loads in the same cycle as the drain.
//  Owner drops early: A sends 2 bytes then deasserts, B VALID -> B granted the next cycle,
//   burst_cnt restarts at 0.
//  MAX_BURST=1 build: both VALID -> Y_SRC sequence is 0,1,0,1...

Source files
------------

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the round-robin byte-mux arbiter.
// FSM encoding, port ids, burst range and the re-arbitration rule.
package mux8_rr_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_e;

   localparam logic SRC_A = 1'b0;
   localparam logic SRC_B = 1'b1;

   localparam int MAX_BURST_MIN = 1;
   localparam int MAX_BURST_MAX = 15;

   // On a tie the port that did not own last wins.
   function automatic arb_state_e rearb(
      input logic last,
      input logic a_v,
      input logic b_v
   );
      arb_state_e r;
      if (a_v && b_v)
         r = (last == SRC_A) ? OWN_B : OWN_A;
      else if (a_v)
         r = OWN_A;
      else if (b_v)
         r = OWN_B;
      else
         r = IDLE;
      return r;
   endfunction

endpackage

// File: rtl/MUX8.sv
// Existing 8-bit 2:1 byte multiplexer.
// S=0 selects A, S=1 selects B.
module MUX8 (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       S,
   output logic [7:0] Y
);

   assign Y = S ? B : A;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin, burst-limited arbiter sharing a byte mux between
// two streaming requesters, with a one-entry registered output slot.
module mux8_rr_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             A_VALID,
   input  logic [WIDTH-1:0] A_DATA,
   output logic             A_READY,
   input  logic             B_VALID,
   input  logic [WIDTH-1:0] B_DATA,
   output logic             B_READY,
   output logic             Y_VALID,
   output logic [WIDTH-1:0] Y_DATA,
   output logic             Y_SRC,
   input  logic             Y_READY,
   output logic             S,
   output logic             BUSY
);

   import mux8_rr_arbiter_pkg::*;

   if (MAX_BURST < MAX_BURST_MIN || MAX_BURST > MAX_BURST_MAX ||
       (2 ** CNT_W) <= MAX_BURST) begin : g_bad_param
      $error("mux8_rr_arbiter: illegal MAX_BURST/CNT_W");
   end

   arb_state_e       state;
   arb_state_e       state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [CNT_W-1:0] cnt_inc;
   logic             gap;
   logic             gap_n;
   logic             last;
   logic             y_valid;
   logic [WIDTH-1:0] y_data;
   logic             y_src;
   logic [WIDTH-1:0] mux_y;
   logic             owner;
   logic             own_valid;
   logic             slot_free;
   logic             xfer;
   logic             leave;

   assign owner     = (state == OWN_B);
   assign own_valid = (state == OWN_A) ? A_VALID :
                      (state == OWN_B) ? B_VALID : 1'b0;
   assign slot_free = !y_valid || Y_READY;
   assign A_READY   = (state == OWN_A) && slot_free && !gap;
   assign B_READY   = (state == OWN_B) && slot_free && !gap;
   assign xfer      = (A_READY && A_VALID) || (B_READY && B_VALID);
   assign cnt_inc   = cnt + 1'b1;
   assign leave     = (state != IDLE) &&
                      ((xfer && cnt_inc == CNT_W'(MAX_BURST)) ||
                       !own_valid);

   if (WIDTH == 8) begin : g_mux8
      MUX8 u_mux (
         .A (A_DATA),
         .B (B_DATA),
         .S (owner),
         .Y (mux_y)
      );
   end else begin : g_mux_n
      assign mux_y = owner ? B_DATA : A_DATA;
   end

   // Every ownership grant out of a burst costs one dead cycle.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gap_n   = 1'b0;
      unique case (state)
         IDLE: begin
            state_n = rearb(last, A_VALID, B_VALID);
            cnt_n   = '0;
         end
         OWN_A, OWN_B: begin
            if (leave) begin
               state_n = rearb(owner, A_VALID, B_VALID);
               cnt_n   = '0;
               gap_n   = (state_n != IDLE);
            end else if (xfer) begin
               cnt_n = cnt_inc;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
         cnt   <= '0;
         gap   <= 1'b0;
         last  <= SRC_B;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         gap   <= gap_n;
         if (xfer)
            last <= owner;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         y_valid <= 1'b0;
         y_data  <= '0;
         y_src   <= SRC_A;
      end else if (xfer) begin
         y_valid <= 1'b1;
         y_data  <= mux_y;
         y_src   <= owner;
      end else if (Y_READY) begin
         y_valid <= 1'b0;
      end
   end

   assign Y_VALID = y_valid;
   assign Y_DATA  = y_data;
   assign Y_SRC   = y_src;
   assign S       = owner;
   assign BUSY    = (state != IDLE) || y_valid;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: directed streams,
// expected bytes queued at issue time, checked by a separate monitor.
module tb_mux8_rr_arbiter;

   typedef struct packed {
      logic       src;
      logic [7:0] data;
   } item_t;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       A_VALID, B_VALID, A_READY, B_READY;
   logic [7:0] A_DATA, B_DATA, Y_DATA;
   logic       Y_VALID, Y_SRC, Y_READY, S, BUSY;

   logic       a1v, b1v, a1r, b1r, y1v, y1s, y1r, s1, busy1;
   logic [7:0] a1d, b1d, y1d;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   item_t      exp_q[$];
   logic       exp1[$];
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int         hs_cyc[$];
   bit         mon_en = 1'b1;
   bit         saw_s = 1'b0;
   bit         ha, hb;
   item_t      e;
   logic       e1;

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   mux8_rr_arbiter #(.WIDTH(8), .MAX_BURST(4), .CNT_W(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .A_VALID(A_VALID), .A_DATA(A_DATA), .A_READY(A_READY),
      .B_VALID(B_VALID), .B_DATA(B_DATA), .B_READY(B_READY),
      .Y_VALID(Y_VALID), .Y_DATA(Y_DATA), .Y_SRC(Y_SRC),
      .Y_READY(Y_READY), .S(S), .BUSY(BUSY)
   );

   mux8_rr_arbiter #(.WIDTH(8), .MAX_BURST(1), .CNT_W(4)) dut1 (
      .CLK(CLK), .RST_N(RST_N),
      .A_VALID(a1v), .A_DATA(a1d), .A_READY(a1r),
      .B_VALID(b1v), .B_DATA(b1d), .B_READY(b1r),
      .Y_VALID(y1v), .Y_DATA(y1d), .Y_SRC(y1s),
      .Y_READY(y1r), .S(s1), .BUSY(busy1)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Producers: present queue heads, pop after a handshake.
   initial begin
      A_VALID = 1'b0; B_VALID = 1'b0;
      A_DATA = 8'h0; B_DATA = 8'h0;
      forever begin
         @(negedge CLK);
         ha = A_VALID && A_READY;
         hb = B_VALID && B_READY;
         @(posedge CLK);
         #1;
         if (ha && qa.size() != 0) void'(qa.pop_front());
         if (hb && qb.size() != 0) void'(qb.pop_front());
         A_VALID = (qa.size() != 0);
         B_VALID = (qb.size() != 0);
         A_DATA = A_VALID ? qa[0] : 8'h00;
         B_DATA = B_VALID ? qb[0] : 8'h00;
      end
   end

   // Monitor for the MAX_BURST=4 instance.
   initial begin
      forever begin
         @(negedge CLK);
         if (S) saw_s = 1'b1;
         if (mon_en && Y_VALID && Y_READY) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_byte: got %0h expected none",
                        Y_DATA);
            end else begin
               e = exp_q.pop_front();
               chk("y_data", Y_DATA, e.data);
               chk("y_src", Y_SRC, e.src);
               hs_cyc.push_back(cyc);
            end
         end
      end
   end

   // Monitor for the MAX_BURST=1 instance.
   initial begin
      forever begin
         @(negedge CLK);
         if (y1v && y1r && exp1.size() != 0) begin
            e1 = exp1.pop_front();
            chk("alt_src", y1s, e1);
            chk("alt_data", y1d, e1 ? 8'hA5 : 8'h5A);
         end
      end
   end

   task automatic do_reset();
      @(posedge CLK);
      #2;
      RST_N = 1'b0;
      qa.delete();
      qb.delete();
      exp_q.delete();
      hs_cyc.delete();
      repeat (2) @(posedge CLK);
      #2;
      RST_N = 1'b1;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || qa.size() != 0 || qb.size() != 0)
             && n < 300) begin
         @(posedge CLK);
         n++;
      end
      chk({name, "_timeout"}, (n >= 300), 0);
      repeat (3) @(posedge CLK);
   endtask

   initial begin
      int n;
      Y_READY = 1'b1;
      y1r = 1'b0; a1v = 1'b0; b1v = 1'b0;
      a1d = 8'h5A; b1d = 8'hA5;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_y_valid", Y_VALID, 0);
      chk("rst_y_data", Y_DATA, 0);
      chk("rst_y_src", Y_SRC, 0);
      chk("rst_s", S, 0);
      chk("rst_a_ready", A_READY, 0);
      chk("rst_b_ready", B_READY, 0);
      chk("rst_busy", BUSY, 0);
      do_reset();

      // Reset mid-burst
      mon_en = 1'b0;
      for (int i = 0; i < 10; i++) qa.push_back(8'h30 + 8'(i));
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!(Y_VALID && A_READY) && n < 50);
      chk("midrst_reach", (n >= 50), 0);
      @(posedge CLK);
      #1;
      RST_N = 1'b0;
      #1;
      chk("midrst_y_valid", Y_VALID, 0);
      chk("midrst_s", S, 0);
      chk("midrst_a_ready", A_READY, 0);
      chk("midrst_b_ready", B_READY, 0);
      qa.delete();
      repeat (2) @(posedge CLK);
      #2;
      RST_N = 1'b1;
      repeat (2) @(posedge CLK);
      mon_en = 1'b1;

      // Single requester A with re-grant bubble
      do_reset();
      saw_s = 1'b0;
      for (int i = 0; i < 6; i++) begin
         qa.push_back(8'h11 + 8'(i));
         exp_q.push_back('{1'b0, 8'h11 + 8'(i)});
      end
      wait_done("single");
      chk("single_count", hs_cyc.size(), 6);
      chk("single_back2back", hs_cyc[1] - hs_cyc[0], 1);
      chk("single_bubble", hs_cyc[4] - hs_cyc[3], 2);
      chk("single_after", hs_cyc[5] - hs_cyc[4], 1);
      chk("single_no_b", saw_s, 0);
      chk("single_idle", BUSY, 0);

      // Contention: 4 A, 4 B, 4 A
      do_reset();
      for (int i = 0; i < 8; i++) qa.push_back(8'hA0 + 8'(i));
      for (int i = 0; i < 4; i++) qb.push_back(8'hB0 + 8'(i));
      for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, 8'hA0 + 8'(i)});
      for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, 8'hB0 + 8'(i)});
      for (int i = 4; i < 8; i++) exp_q.push_back('{1'b0, 8'hA0 + 8'(i)});
      wait_done("contend");
      chk("contend_count", hs_cyc.size(), 12);
      chk("contend_swap_bubble", hs_cyc[4] - hs_cyc[3], 2);

      // Backpressure
      do_reset();
      Y_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         qa.push_back(8'hC0 + 8'(i));
         exp_q.push_back('{1'b0, 8'hC0 + 8'(i)});
      end
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!Y_VALID && n < 50);
      chk("bp_reach", (n >= 50), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         chk("bp_y_valid", Y_VALID, 1);
         chk("bp_y_data", Y_DATA, 8'hC0);
         chk("bp_a_ready", A_READY, 0);
         chk("bp_b_ready", B_READY, 0);
      end
      @(posedge CLK);
      #2;
      Y_READY = 1'b1;
      @(negedge CLK);
      chk("bp_release_ready", A_READY, 1);
      @(posedge CLK);
      #1;
      chk("bp_reload_valid", Y_VALID, 1);
      chk("bp_reload_data", Y_DATA, 8'hC1);
      wait_done("bp");

      // Owner drops early, B takes over
      do_reset();
      qa.push_back(8'hD0);
      qa.push_back(8'hD1);
      exp_q.push_back('{1'b0, 8'hD0});
      exp_q.push_back('{1'b0, 8'hD1});
      for (int i = 0; i < 3; i++) begin
         qb.push_back(8'hE0 + 8'(i));
         exp_q.push_back('{1'b1, 8'hE0 + 8'(i)});
      end
      wait_done("drop");
      chk("drop_count", hs_cyc.size(), 5);
      chk("drop_idle", BUSY, 0);

      // MAX_BURST=1 strict alternation
      do_reset();
      for (int i = 0; i < 6; i++) exp1.push_back(1'(i % 2));
      @(posedge CLK);
      #1;
      a1v = 1'b1; b1v = 1'b1; y1r = 1'b1;
      n = 0;
      while (exp1.size() != 0 && n < 100) begin
         @(posedge CLK);
         n++;
      end
      chk("alt_timeout", (n >= 100), 0);
      #1;
      y1r = 1'b0; a1v = 1'b0; b1v = 1'b0;
      repeat (2) @(posedge CLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
